alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised, handshaked execute unit for the pipelined RISC-V core. It extends the single-cycle add/sub/xor/or/and ALU with:
  - shifts and set-less-than (registered, one cycle);
  - iterative multiply, divide and remainder (multi-cycle).
- Sits in EX and drives valid/ready on both sides, so the pipeline stalls on long operations.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), derived; shift-amount bits taken from arg2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  unit accepts request this cycle
- op  in  4  0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU
- arg1  in  WIDTH  operand 1 (dividend / multiplicand)
- arg2  in  WIDTH  operand 2 (divisor / multiplier / shift amount)
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- result  out  WIDTH  result, stable while out_valid=1 and out_ready=0
- busy  out  1  iterative op in progress

Behaviour:
- States:
  - IDLE: no result held.
  - ITER: iterating.
  - DONE: result held.
- Reset: state=IDLE, out_valid=0, busy=0, result=0, iteration counter=0, in_ready=1. Reset mid-ITER or mid-DONE aborts the op and drops the result with no output.
- in_ready = (state==IDLE) | (state==DONE & out_ready), combinational. Accept = in_valid & in_ready. arg1, arg2 and op are sampled only on accept.
- Ops 0-9, accepted at cycle N:
  - result is registered at edge N+1, and the next state is DONE.
  - This gives back-to-back throughput of 1/cycle when out_ready=1.
- Ops 10-15, accepted at cycle N:
  - state ITER, busy=1, one bit per cycle for WIDTH cycles.
  - Enter DONE with out_valid=1 at edge N+WIDTH+1; busy drops at the same edge.
- DONE: hold result until out_ready=1. On that cycle either return to IDLE, or take a new accept and go directly to that op's next state.
- ITER ignores in_valid (in_ready=0) and out_ready.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Shifts use arg2[SHW-1:0]; SRA replicates arg1 MSB.
  - SLT is signed, SLTU unsigned; result 1 or 0, zero-extended.
  - MUL gives the low WIDTH bits. MULHU gives the high WIDTH bits of the unsigned 2*WIDTH product, computed by shift-add.
  - DIV/DIVU/REM/REMU use restoring division on magnitudes. For signed ops, take absolute values, then negate the quotient if the operand signs differ and negate the remainder if arg1 was negative. Sign fix-up happens in the final iteration cycle, not as an extra cycle.
- Boundary cases:
  - Divide by zero: quotient all-ones (DIV and DIVU); remainder = arg1. Latency is unchanged (WIDTH cycles).
  - Signed overflow, arg1=MIN and arg2=-1: DIV returns MIN, REM returns 0.
  - Latency is fixed regardless of operand values; no early-out.
  - If out_ready is held low, out_valid and result stay constant indefinitely and in_ready=0.

Test Plan:
- Reset, then ADD 7+5 with out_ready=1 -> result=12 one cycle after accept. Then SUB 0-1 -> 0xFFFFFFFF. Back-to-back accepts on consecutive cycles.
- SRA 0x80000000 by 0x24 (shift 4) -> 0xF8000000. SLT -1<1 -> 1. SLTU 0xFFFFFFFF<1 -> 0.
- MUL 0xFFFFFFFF*0xFFFFFFFF:
  - MUL -> 0x00000001 and MULHU -> 0xFFFFFFFE.
  - out_valid asserts exactly 33 cycles after accept; busy=1 and in_ready=0 throughout.
- Signed divide, DIV -7/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF. DIVU 100/0 -> 0xFFFFFFFF and REMU -> 100. DIV 0x80000000/-1 -> 0x80000000 and REM -> 0.
- Backpressure: complete an ADD with out_ready=0 for 5 cycles -> result stable, in_ready=0. Raise out_ready with in_valid=1 -> new op accepted on the same cycle.
- Assert reset during ITER of a DIVU -> out_valid never rises. Next cycle state is IDLE, in_ready=1, result=0.

Source files
------------

// File: rtl/alu_muldiv.sv
// Handshaked EX-stage execute unit: one-cycle ALU/shift/compare ops plus
// iterative shift-add multiply and restoring divide/remainder.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] arg1,
    input  logic [WIDTH-1:0] arg2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_XOR   = 4'd2,
        OP_OR    = 4'd3,
        OP_AND   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIV   = 4'd12,
        OP_DIVU  = 4'd13,
        OP_REM   = 4'd14,
        OP_REMU  = 4'd15
    } op_t;

    // Control and result registers.
    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Iteration datapath: hi/lo form the product or remainder/quotient pair,
    // b holds the multiplicand or divisor magnitude.
    op_t              op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dzero_q, dzero_d;

    op_t              op_in;
    logic             accept;
    logic             is_iter_op;
    logic             is_div_op;
    logic             is_signed_div;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH:0]   rem_sh;
    logic             qbit;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] iter_result;
    logic             iter_div;
    logic             last_iter;

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_ITER);
    assign result    = result_q;

    // Request decode: ops 10-15 iterate, 12-15 divide, 12 and 14 are signed.
    assign op_in         = op_t'(op);
    assign is_iter_op    = op[3] & (op[2] | op[1]);
    assign is_div_op     = op[3] & op[2];
    assign is_signed_div = is_div_op & ~op[0];
    assign shamt         = arg2[SHW-1:0];

    assign dividend_mag = (is_signed_div && arg1[WIDTH-1]) ? -arg1 : arg1;
    assign divisor_mag  = (is_signed_div && arg2[WIDTH-1]) ? -arg2 : arg2;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_result = '0;
        case (op_in)
            OP_ADD:  alu_result = arg1 + arg2;
            OP_SUB:  alu_result = arg1 - arg2;
            OP_XOR:  alu_result = arg1 ^ arg2;
            OP_OR:   alu_result = arg1 | arg2;
            OP_AND:  alu_result = arg1 & arg2;
            OP_SLL:  alu_result = arg1 << shamt;
            OP_SRL:  alu_result = arg1 >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(arg1) >>> shamt);
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(arg1) < $signed(arg2)};
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, arg1 < arg2};
            default: alu_result = '0;
        endcase
    end

    // One shift-add multiply step: add multiplicand if multiplier LSB set,
    // then shift the {hi,lo} pair right by one.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // One restoring divide step; when qbit is set the true difference is
    // below b, so a WIDTH-bit subtraction is exact.
    assign rem_sh = {hi_q, lo_q[WIDTH-1]};
    assign qbit   = (rem_sh >= {1'b0, b_q});
    assign div_hi = qbit ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
    assign div_lo = {lo_q[WIDTH-2:0], qbit};

    // Sign fix-up folded into the last step; divide-by-zero keeps all-ones.
    assign quo_fix = (neg_quo_q && !dzero_q) ? -div_lo : div_lo;
    assign rem_fix = neg_rem_q ? -div_hi : div_hi;

    assign iter_div  = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign last_iter = (cnt_q == SHW'(WIDTH - 1));

    always_comb begin
        iter_result = rem_fix;
        case (op_q)
            OP_MUL:          iter_result = mul_lo;
            OP_MULHU:        iter_result = mul_hi;
            OP_DIV, OP_DIVU: iter_result = quo_fix;
            default:         iter_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dzero_d   = dzero_q;

        case (state_q)
            S_ITER: begin
                cnt_d = cnt_q + SHW'(1);
                if (iter_div) begin
                    hi_d = div_hi;
                    lo_d = div_lo;
                end else begin
                    hi_d = mul_hi;
                    lo_d = mul_lo;
                end
                if (last_iter) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = iter_result;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
            end
        endcase

        // Accept is only possible from IDLE or a draining DONE.
        if (accept) begin
            op_d = op_in;
            if (is_iter_op) begin
                state_d   = S_ITER;
                cnt_d     = '0;
                hi_d      = '0;
                lo_d      = is_div_op ? dividend_mag : arg2;
                b_d       = is_div_op ? divisor_mag  : arg1;
                neg_quo_d = is_signed_div & (arg1[WIDTH-1] ^ arg2[WIDTH-1]);
                neg_rem_d = is_signed_div & arg1[WIDTH-1];
                dzero_d   = (arg2 == '0);
            end else begin
                state_d  = S_DONE;
                result_d = alu_result;
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge value of every other.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // NOTE: operand/working registers carry no reset; they are always loaded
    // on accept before being read, so reset would only cost routing.
    always_ff @(posedge clk) begin
        op_q      <= op_d;
        hi_q      <= hi_d;
        lo_q      <= lo_d;
        b_q       <= b_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
        dzero_q   <= dzero_d;
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed boundary cases plus randomized
// ops scored against a plain-arithmetic reference model.
module tb_alu_muldiv;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] arg1;
    logic [W-1:0] arg2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .arg1      (arg1),
        .arg2      (arg2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic string op_name(input logic [3:0] o);
        case (o)
            4'd0: return "ADD";   4'd1: return "SUB";   4'd2: return "XOR";
            4'd3: return "OR";    4'd4: return "AND";   4'd5: return "SLL";
            4'd6: return "SRL";   4'd7: return "SRA";   4'd8: return "SLT";
            4'd9: return "SLTU";  4'd10: return "MUL";  4'd11: return "MULHU";
            4'd12: return "DIV";  4'd13: return "DIVU"; 4'd14: return "REM";
            default: return "REMU";
        endcase
    endfunction

    // Reference model: RISC-V M-extension semantics with native arithmetic.
    function automatic logic [W-1:0] ref_model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0]      p;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic [4:0]          sh;
        logic                ovf;
        sa  = a;
        sb  = b;
        sh  = b[4:0];
        p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        ovf = (a == MIN) && (b == '1);
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a ^ b;
            4'd3:  return a | b;
            4'd4:  return a & b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return $unsigned(sa >>> sh);
            4'd8:  return {{(W-1){1'b0}}, sa < sb};
            4'd9:  return {{(W-1){1'b0}}, a < b};
            4'd10: return p[W-1:0];
            4'd11: return p[2*W-1:W];
            4'd12: return (b == '0) ? '1 : (ovf ? MIN : $unsigned(sa / sb));
            4'd13: return (b == '0) ? '1 : a / b;
            4'd14: return (b == '0) ? a : (ovf ? '0 : $unsigned(sa % sb));
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    // Issue one op with out_ready held by the caller; report result, edges from
    // accept to out_valid, and samples where busy/in_ready were wrong meanwhile.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int lat, output int bad_ctrl);
        int waited;
        waited   = 0;
        bad_ctrl = 0;
        @(negedge clk);
        op       = o;
        arg1     = a;
        arg2     = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            res      = 'x;
            lat      = -1;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad_ctrl++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        arg1      = '0;
        arg2      = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        checks++;
        if (result !== '0) begin errors++; $display("FAIL reset_result: got %h, expected 0", result); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] exp_res);
        logic [W-1:0] res;
        int           lat;
        int           bad;
        int           exp_lat;
        exp_lat = (o >= 4'd10) ? W + 1 : 1;
        run_op(o, a, b, res, lat, bad);
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL %s_result: got %h, expected %h", tag, res, exp_res); end
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d, expected %0d", tag, lat, exp_lat); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s_busy_in_ready: %0d bad samples, expected 0", tag, bad); end
    endtask

    task automatic test_alu();
        out_ready = 1'b1;
        test_directed("add",  4'd0, 32'd7,          32'd5,          32'd12);
        test_directed("sub",  4'd1, 32'd0,          32'd1,          32'hFFFF_FFFF);
        test_directed("sra",  4'd7, 32'h8000_0000,  32'h24,         32'hF800_0000);
        test_directed("srl",  4'd6, 32'h8000_0000,  32'd31,         32'd1);
        test_directed("sll",  4'd5, 32'h0000_0003,  32'h21,         32'd6);
        test_directed("slt",  4'd8, 32'hFFFF_FFFF,  32'd1,          32'd1);
        test_directed("sltu", 4'd9, 32'hFFFF_FFFF,  32'd1,          32'd0);
    endtask

    task automatic test_muldiv();
        out_ready = 1'b1;
        test_directed("mul",      4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        test_directed("mulhu",    4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        test_directed("div",      4'd12, -32'sd7,       32'd2,         32'hFFFF_FFFD);
        test_directed("rem",      4'd14, -32'sd7,       32'd2,         32'hFFFF_FFFF);
        test_directed("divu_z",   4'd13, 32'd100,       32'd0,         32'hFFFF_FFFF);
        test_directed("remu_z",   4'd15, 32'd100,       32'd0,         32'd100);
        test_directed("div_z",    4'd12, -32'sd7,       32'd0,         32'hFFFF_FFFF);
        test_directed("rem_z",    4'd14, -32'sd7,       32'd0,         32'hFFFF_FFF9);
        test_directed("div_ovf",  4'd12, MIN,           32'hFFFF_FFFF, MIN);
        test_directed("rem_ovf",  4'd14, MIN,           32'hFFFF_FFFF, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [3:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            o = 4'($urandom_range(0, 9));
            a = $urandom;
            b = $urandom;
            exp_res = ref_model(o, a, b);
            @(negedge clk);
            op       = o;
            arg1     = a;
            arg2     = b;
            in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b, expected 1", i, in_ready); end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== exp_res) begin
                errors++;
                $display("FAIL b2b_%s[%0d]: got valid=%b result=%h, expected valid=1 result=%h", op_name(o), i, out_valid, result, exp_res);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] exp_res;
        int           lat;
        int           bad;
        int           exp_lat;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 7) == 0) ? MIN : $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                2:       b = W'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            exp_res = ref_model(o, a, b);
            exp_lat = (o >= 4'd10) ? W + 1 : 1;
            run_op(o, a, b, res, lat, bad);
            checks++;
            if (res !== exp_res || lat != exp_lat || bad != 0) begin
                errors++;
                $display("FAIL rand_%s[%0d] a=%h b=%h: got result=%h lat=%0d bad=%0d, expected result=%h lat=%0d bad=0",
                         op_name(o), i, a, b, res, lat, bad, exp_res, exp_lat);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        op        = 4'd0;
        arg1      = 32'd3;
        arg2      = 32'd4;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        op   = 4'd2;
        arg1 = 32'h0000_00F0;
        arg2 = 32'h0000_00FF;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd7) begin
            errors++;
            $display("FAIL bp_first: got valid=%b result=%h, expected valid=1 result=00000007", out_valid, result);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b result=%h in_ready=%b, expected valid=1 result=00000007 in_ready=0",
                         i, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b, expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h0000_000F) begin
            errors++;
            $display("FAIL bp_new_op: got valid=%b result=%h, expected valid=1 result=0000000f", out_valid, result);
        end
    endtask

    task automatic test_reset_iter();
        int           seen;
        logic [W-1:0] res;
        int           lat;
        int           bad;
        seen = 0;
        @(negedge clk);
        out_ready = 1'b1;
        op        = 4'd13;
        arg1      = 32'd1000;
        arg2      = 32'd7;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_iter_busy: got %b, expected 1", busy); end
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
            errors++;
            $display("FAIL rst_iter_state: got valid=%b busy=%b in_ready=%b result=%h, expected 0 0 1 00000000",
                     out_valid, busy, in_ready, result);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_iter_no_output: out_valid high %0d cycles, expected 0", seen); end
        run_op(4'd0, 32'd20, 32'd22, res, lat, bad);
        checks++;
        if (res !== 32'd42 || lat != 1) begin
            errors++;
            $display("FAIL rst_iter_recover: got result=%h lat=%0d, expected result=0000002a lat=1", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_iter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
